// File: rtl/seg_scan_pkg.sv
// Purpose: shared constants for the 7-segment scan capture (patterns, FSM states, digit slots).
// Latency: n/a (package).
// Backpressure: n/a (package).
package seg_scan_pkg;

    // Active-high segment patterns, bit order g..a.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7C;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h67;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_COMMIT
    } state_t;

    // Selector bit / digit slot positions.
    localparam int DIG_MIN_U = 0;
    localparam int DIG_MIN_D = 1;
    localparam int DIG_HRS_U = 2;
    localparam int DIG_HRS_D = 3;

    // Legal 24 h time: minutes tens at most 5, hours at most 23.
    function automatic logic legal_time(input logic [3:0] hrs_d,
                                        input logic [3:0] hrs_u,
                                        input logic [3:0] min_d);
        return (min_d <= 4'd5) &&
               ((hrs_d < 4'd2) || ((hrs_d == 4'd2) && (hrs_u <= 4'd3)));
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Purpose: map a 7-bit segment pattern back to its BCD digit.
// Latency: combinational.
// Backpressure: none.
// Ports: pattern (g..a, active-high) in; valid (pattern is a known digit) and value (BCD) out.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] value
);

    always_comb begin
        valid = 1'b1;
        value = 4'd0;
        case (pattern)
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Purpose: watch a multiplexed 4-digit 7-segment bus, decode each settled digit, commit whole frames.
// Latency: pin change to sample 2+SETTLE_CYCLES cycles; completing sample to frame_valid/digits 1 cycle.
// Backpressure: none; free-running monitor, every output registered.
// Ports: clk, reset (async, active-high); segments[7:0] (bit 7 = dp), selector[3:0] (active-low)
//        in; digits[15:0] {hrs_d,hrs_u,min_d,min_u}, dots[3:0], frame_valid, time_valid,
//        pattern_err, select_err, stale out.
// Build option: SEG_SCAN_DP_EN enables decimal-point capture; otherwise dots is 4'b0000.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int STALE_CYCLES  = 216000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  segments,
    input  logic [3:0]  selector,
    output logic [15:0] digits,
    output logic [3:0]  dots,
    output logic        frame_valid,
    output logic        time_valid,
    output logic        pattern_err,
    output logic        select_err,
    output logic        stale
);

`ifdef SEG_SCAN_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
    logic unused_dp;
    assign unused_dp = segments[7];
`endif
    localparam int IW = 4 + SW;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LIM = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] SAMPLE_AT  = CW'(SETTLE_CYCLES - 1);
    localparam logic [25:0]   STALE_LIM  = 26'(STALE_CYCLES);
    // Selector flops reset to "all digits off" so an idle bus never looks like a collision.
    localparam logic [IW-1:0] SYNC_RST   = {4'b1111, {SW{1'b0}}};

    logic [IW-1:0] sync1, sync2, prev;
    logic [CW-1:0] settle_cnt;
    logic          changed, sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= SYNC_RST;
            sync2      <= SYNC_RST;
            prev       <= SYNC_RST;
            settle_cnt <= '0;
        end else begin
            sync1 <= {selector, segments[SW-1:0]};
            sync2 <= sync1;
            prev  <= sync2;
            if (changed)
                settle_cnt <= '0;
            else if (settle_cnt != SETTLE_LIM)
                settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign changed = (sync2 != prev);
    // Fires once per dwell: the cycle the counter steps onto its saturation value.
    assign sample  = !changed && (settle_cnt == SAMPLE_AT);

    logic [3:0] sel_s, zeros;
    logic       one_low, multi_low, dec_valid;
    logic [3:0] dec_value;

    assign sel_s     = sync2[IW-1 -: 4];
    assign zeros     = ~sel_s;
    assign one_low   = (zeros != 4'b0) && ((zeros & (zeros - 4'd1)) == 4'b0);
    assign multi_low = (zeros != 4'b0) && !one_low;

    seg7_decode u_decode (
        .pattern (sync2[6:0]),
        .valid   (dec_valid),
        .value   (dec_value)
    );

    logic            good, bad_pat, bad_sel, commit;
    logic [3:0][3:0] shadow, shadow_n;
    logic [3:0]      seen, seen_n;
    state_t          state;
    logic [25:0]     stale_cnt;

    assign good    = sample && one_low && dec_valid;
    assign bad_pat = sample && one_low && !dec_valid;
    assign bad_sel = sample && multi_low;

    always_comb begin
        shadow_n = shadow;
        seen_n   = seen;
        if (good) begin
            for (int i = 0; i < 4; i++)
                if (zeros[i]) shadow_n[i] = dec_value;
            seen_n = seen | zeros;
        end
    end

    assign commit = good && (seen_n == 4'b1111);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            seen        <= '0;
            shadow      <= '0;
            digits      <= '0;
            frame_valid <= 1'b0;
            time_valid  <= 1'b0;
            pattern_err <= 1'b0;
            select_err  <= 1'b0;
            stale       <= 1'b0;
            stale_cnt   <= '0;
        end else begin
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            select_err  <= 1'b0;

            if (bad_sel || bad_pat) begin
                select_err  <= bad_sel;
                pattern_err <= bad_pat;
                seen        <= '0;
                state       <= ST_IDLE;
            end else if (good) begin
                shadow <= shadow_n;
                if (commit) begin
                    digits      <= shadow_n;
                    frame_valid <= 1'b1;
                    seen        <= '0;
                    state       <= ST_COMMIT;
                end else begin
                    seen  <= seen_n;
                    state <= ST_ACQUIRE;
                end
            end else if (state == ST_COMMIT) begin
                state <= ST_ACQUIRE;
            end

            // A commit in the timeout cycle wins: counter and stale both clear.
            if (commit) begin
                stale_cnt  <= '0;
                stale      <= 1'b0;
                time_valid <= legal_time(shadow_n[DIG_HRS_D], shadow_n[DIG_HRS_U],
                                         shadow_n[DIG_MIN_D]);
            end else if (stale_cnt != STALE_LIM) begin
                stale_cnt <= stale_cnt + 26'd1;
                if (stale_cnt + 26'd1 == STALE_LIM) begin
                    stale      <= 1'b1;
                    time_valid <= 1'b0;
                end
            end
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [3:0] dp_shadow, dp_shadow_n;

    always_comb begin
        dp_shadow_n = dp_shadow;
        if (good)
            dp_shadow_n = (dp_shadow & ~zeros) | (zeros & {4{sync2[7]}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_shadow <= '0;
            dots      <= '0;
        end else begin
            dp_shadow <= dp_shadow_n;
            if (commit && !(bad_sel || bad_pat))
                dots <= dp_shadow_n;
        end
    end
`else
    assign dots = 4'b0000;
`endif

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

- Receive-side monitor for the multiplexed 4-digit 7-segment display bus driven by the clock core.
- Samples the segment and selector lines, rejects unsettled and invalid states, and decodes each pattern back to BCD.
- Reassembles the four digits into a committed time word, flagging legality and bus stall.
- Sits beside the display pins in the board top and in the bench, as a self-check and read-back path.

## Interface
- `SETTLE_CYCLES`, 16: cycles that synchronized {selector, segments} must hold unchanged before one sample is taken.
- `STALE_CYCLES`, 216000: cycles without a commit before `stale` asserts (8 ms at 27 MHz).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `segments` in 8: bit 7 = decimal point; bits 6:0 = segments g..a; all active-high.
- `selector` in 4: active-low digit enables. Bit 0 = min_u, 1 = min_d, 2 = hrs_u, 3 = hrs_d.
- `digits` out 16: committed {hrs_d, hrs_u, min_d, min_u}, BCD.
- `dots` out 4: committed decimal points; `dots[i]` was sampled while `selector[i]` was low.
- `frame_valid` out 1: one-cycle pulse per commit.
- `time_valid` out 1: level; the last commit is a legal 24 h time and `stale` is 0.
- `pattern_err` out 1: one-cycle pulse when an undecodable pattern is sampled.
- `select_err` out 1: one-cycle pulse when a sample sees more than one selector bit low.
- `stale` out 1: level; no commit within `STALE_CYCLES`.

## Operation
- **Synchronization:** two-flop synchronizer on all 12 input bits. All further logic uses the synchronized values.
- **Settle counter:**
  - Cleared on any change of the synchronized 12 bits; otherwise saturates at `SETTLE_CYCLES`.
  - A sample is taken once per dwell, on the cycle the counter first reaches `SETTLE_CYCLES`.
- **Selector classification at sample time:**
  - Exactly one bit low: digit i, decode.
  - All high: blank interval; no sample, no error.
  - Two or more low: `select_err`, no update.
- **Decode:** 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7C=6, 0x07=7, 0x7F=8, 0x67=9. Any other value, including 0x00, raises `pattern_err`.
- **Valid sample:** writes `shadow[i]` and sets `seen[i]`. Re-sampling the same digit overwrites the shadow; `seen` is unchanged.
- **State machine:**
  - IDLE: entered on reset or any error. The first valid sample goes to ACQUIRE.
  - ACQUIRE: accumulates samples. When `seen` reaches 4'b1111, go to COMMIT.
  - COMMIT: lasts one cycle. Copies shadows to `digits`/`dots`, pulses `frame_valid`, evaluates legality, clears `seen`, returns to ACQUIRE.
  - Any `pattern_err` or `select_err` clears `seen` and returns to IDLE.
- **Legality:** min_d ≤ 5 and {hrs_d, hrs_u} ≤ 23. `time_valid` takes this result at commit.
- **Stale counter:**
  - 26 bits, cleared at commit, saturating.
  - On reaching `STALE_CYCLES`: `stale` = 1 and `time_valid` = 0. `digits` and `dots` hold.

## Timing
- Reset values: `digits` 0, `dots` 0, all flags 0, state IDLE, `seen` 0, counters 0.
- Asynchronous reset mid-frame discards all shadows.
- Pin change to sample: 2 + `SETTLE_CYCLES` cycles. Completing sample to `frame_valid`/`digits` update: 1 cycle. All outputs are registered.
- Error pulses occur in the sample cycle + 1.
- Collisions:
  - Commit and stale timeout in the same cycle: commit wins, and `stale` ends at 0.
  - Error and completing sample in the same cycle: error wins, and no commit occurs.
- Dwell shorter than 2 + `SETTLE_CYCLES`: that digit is never sampled. No error is raised; the frame simply does not complete.

## Configuration
- Macro: `SEG_SCAN_DP_EN`.
- Defined: bit 7 is synchronized, included in change detection, and captured into the dot shadows. `dots` reflects the committed values.
- Undefined: bit 7 is not synchronized and is ignored everywhere. `dots` is tied to 4'b0000.

## Structure
- Package `seg_scan_pkg` holds:
  - the `SEG_0`..`SEG_9` pattern constants;
  - the state enum (IDLE, ACQUIRE, COMMIT);
  - the digit index constants.
- Sub-module `seg7_decode`: combinational, 7-bit pattern to {valid, 4-bit value}.

## Test plan
- **Clean frame:** `SETTLE_CYCLES`=16. Scan 12:34 as 0x66@1110, 0x4F@1101, 0x5B@1011, 0x06@0111, 32 cycles each. Expect `digits`=16'h1234, exactly one `frame_valid`, `time_valid`=1.
- **Short dwell:** each digit held 10 cycles. Expect no sample, no `frame_valid`, no errors.
- **Bad pattern:** 0x7B on the hrs_u slot. Expect a `pattern_err` pulse and no commit that scan; the next clean scan commits 16'h1234.
- **Selector collision and legality:**
  - `selector`=4'b1100 for 32 cycles: expect one `select_err`.
  - A clean scan of 25:61: expect `frame_valid` with `time_valid`=0.
- **Stall and reset:**
  - `STALE_CYCLES`=1000, `selector` held at 4'b1111 after a commit. Expect `stale`=1 and `time_valid`=0 at 1000 cycles, `digits` holding 16'h1234.
  - `reset` asserted mid-scan. Expect all outputs 0 immediately.
